// File: rtl/counter_ctrl.sv
// Prescaled up-counter with start/stop/pause control; counts 0..term, one tick per presc+1 cycles.
// Optional build macro COUNTER_CTRL_AUTORELOAD_EN: terminal tick restarts from 0 instead of entering DONE.
module counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] prescale,
  output logic [WIDTH-1:0]   Q,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   term, term_nxt, q_nxt;
  logic [PRESC_W-1:0] presc, presc_nxt, pcnt, pcnt_nxt;
  logic               tick_nxt, done_nxt, busy_nxt;
  logic               wrap, last;

  assign wrap = (pcnt == presc);
  assign last = (Q == term);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      term  <= '0;
      presc <= '0;
      pcnt  <= '0;
      Q     <= '0;
      tick  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      term  <= term_nxt;
      presc <= presc_nxt;
      pcnt  <= pcnt_nxt;
      Q     <= q_nxt;
      tick  <= tick_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
    end
  end

  // stop outranks everything; start is only honoured from IDLE/DONE, which also gives it priority over pause
  always_comb begin
    state_nxt = state;
    term_nxt  = term;
    presc_nxt = presc;
    pcnt_nxt  = pcnt;
    q_nxt     = Q;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      q_nxt     = '0;
      pcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            term_nxt  = load_val;
            presc_nxt = prescale;
            q_nxt     = '0;
            pcnt_nxt  = '0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt = PAUSE;
          end else if (wrap) begin
            tick_nxt = 1'b1;
            pcnt_nxt = '0;
            if (!last) begin
              q_nxt = Q + 1'b1;
            end else begin
              done_nxt = 1'b1;
`ifdef COUNTER_CTRL_AUTORELOAD_EN
              q_nxt = '0;
`else
              state_nxt = DONE;
`endif
            end
          end else begin
            pcnt_nxt = pcnt + 1'b1;
          end
        end
        PAUSE: begin
          // prescaler stays frozen, so the run resumes mid-period
          if (!pause) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
  end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the count width in bits.
REQ-002 The block SHALL have parameter PRESC_W, default 4, setting the prescaler width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstb, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin a count run.
REQ-006 The block SHALL have port stop, input, 1 bit: abort the run and return to idle.
REQ-007 The block SHALL have port pause, input, 1 bit: level-sensitive hold of a running count.
REQ-008 The block SHALL have port load_val, input, WIDTH bits: terminal count, captured at start.
REQ-009 The block SHALL have port prescale, input, PRESC_W bits: tick divider, captured at start.
REQ-010 The block SHALL have port Q, output, WIDTH bits: current count value.
REQ-011 The block SHALL have port tick, output, 1 bit: one-cycle pulse on each count advance.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when the terminal count is reached.

Function
REQ-014 The FSM SHALL have four states, IDLE, RUN, PAUSE and DONE, with all outputs registered.
REQ-015 In IDLE or DONE, start=1 SHALL capture load_val into term and prescale into presc, clear Q and the prescaler, and enter RUN on the next cycle.
REQ-016 start SHALL be ignored in RUN and PAUSE; load_val and prescale changes after capture SHALL have no effect.
REQ-017 In RUN, the prescaler SHALL count 0..presc, and tick SHALL pulse for one cycle when the prescaler equals presc (then wrap to 0); presc=0 SHALL tick every cycle.
REQ-018 On tick with Q!=term, Q SHALL become Q+1 (modulo 2^WIDTH); on tick with Q==term, done SHALL pulse, Q SHALL hold term, and the state SHALL become DONE.
REQ-019 A run SHALL take (term+1)*(presc+1) RUN cycles from RUN entry to done; term=0 SHALL give done on the first tick with Q=0.
REQ-020 In RUN, pause=1 SHALL enter PAUSE with no tick that cycle; in PAUSE, Q and the prescaler SHALL freeze, and pause=0 SHALL return to RUN, resuming from the frozen prescaler value.
REQ-021 stop=1 SHALL, in any state, enter IDLE and clear Q, the prescaler, tick and done.
REQ-022 Input priority in a single cycle SHALL be stop > start > pause.
REQ-023 In DONE, Q SHALL hold term and busy SHALL be 0 until start or stop.
REQ-024 busy SHALL be 1 exactly while the state is RUN or PAUSE.

Reset
REQ-025 rstb=0 SHALL, asynchronously, force state IDLE, Q=0, prescaler=0, term=0, presc=0, tick=0, busy=0 and done=0.
REQ-026 Reset asserted mid-run SHALL abort the run with no done pulse; after rstb rises, the block SHALL wait in IDLE for start.

Configuration
REQ-027 With macro COUNTER_CTRL_AUTORELOAD_EN defined, a terminal tick SHALL pulse done, set Q to 0 and keep the state in RUN, repeating until stop.
REQ-028 Without COUNTER_CTRL_AUTORELOAD_EN, the terminal tick SHALL enter DONE per REQ-018, and the DONE state SHALL be reachable only in this build.

Verification
REQ-029 The bench SHALL check: reset, then start with load_val=5 and prescale=0 -> Q steps 0..5 on consecutive cycles, done pulses once with Q=5, busy falls, and Q holds 5.
REQ-030 The bench SHALL check: load_val=3 and prescale=2 -> tick every 3rd cycle, and done 12 RUN cycles after RUN entry.
REQ-031 The bench SHALL check: pause held 4 cycles at Q=2 mid-run (prescale=1) -> Q and tick frozen, then the count resumes with total RUN cycles unchanged.
REQ-032 The bench SHALL check: stop and start asserted together at Q=3 -> IDLE and Q=0 next cycle, with no done pulse.
REQ-033 The bench SHALL check: rstb pulsed low at Q=4 asynchronously, between clock edges -> all outputs 0 immediately, and the count stays idle until the next start.
REQ-034 The bench SHALL check: with COUNTER_CTRL_AUTORELOAD_EN and load_val=2, prescale=0 -> Q sequence 0,1,2,0,1,2 with done on each Q=2 tick and busy held 1.
